// File: rtl/id_stage_pipe_pkg.sv
// id_pkg: shared ALU-op, opcode and branch funct3 encodings plus the control bundle for id_stage_pipe.
// Rev 1.0
`default_nettype none

package id_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1100;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;

  // alt is instr[30]; it selects SUB only for register-register ops, SRA for both forms.
  function automatic logic [3:0] alu_op_decode(input logic [2:0] f3, input logic alt,
                                               input logic is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_pipe_branch_cmp.sv
// branch_cmp: combinational XLEN-wide conditional-branch comparator; undefined funct3 is never taken.
// Rev 1.0
`default_nettype none

module branch_cmp
  import id_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (a == b);
      F3_BNE:  taken = (a != b);
      F3_BLT:  taken = ($signed(a) <  $signed(b));
      F3_BGE:  taken = ($signed(a) >= $signed(b));
      F3_BLTU: taken = (a <  b);
      F3_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode, ID-stage branch resolution, hazard detection and ID/EX register.
// Optional performance counters enabled by macro ID_PERF_CNT_EN. Rev 1.0
`default_nettype none

module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_id_valid,
  input  logic [31:0]       if_id_instr,
  input  logic [XLEN-1:0]   if_id_pc,
  input  logic [XLEN-1:0]   rf_rs1_val,
  input  logic [XLEN-1:0]   rf_rs2_val,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_regwrite,
  input  logic              ex_mem_memread,
  input  logic [XLEN-1:0]   ex_mem_result,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_regwrite,
  input  logic [XLEN-1:0]   mem_wb_data,
  input  logic              ex_hold,
  output logic              stall,
  output logic              flush_if,
  output logic [XLEN-1:0]   branch_target,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_alu_src,
  output logic [3:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   pc;
  } idex_t;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1_f, rs2_f, rd_f;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, shamt;

  assign opcode = if_id_instr[6:0];
  assign funct3 = if_id_instr[14:12];
  assign rs1_f  = REG_AW'(if_id_instr[19:15]);
  assign rs2_f  = REG_AW'(if_id_instr[24:20]);
  assign rd_f   = REG_AW'(if_id_instr[11:7]);
  assign imm_i  = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:20]};
  assign imm_s  = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
  assign imm_b  = {{(XLEN-13){if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                   if_id_instr[30:25], if_id_instr[11:8], 1'b0};
  // RV64 shift immediates carry a 6-bit shamt, RV32 only 5 bits.
  assign shamt  = (XLEN == 64) ? XLEN'(if_id_instr[25:20]) : XLEN'(if_id_instr[24:20]);

  ctrl_t           ctrl;
  logic [XLEN-1:0] imm;
  logic            uses_rs1, uses_rs2, writes_rd, is_branch;

  always_comb begin
    ctrl      = '0;
    imm       = '0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.regwrite = 1'b1;
        ctrl.alu_op   = alu_op_decode(funct3, if_id_instr[30], 1'b1);
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        writes_rd     = 1'b1;
      end
      OP_I: begin
        ctrl.regwrite = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_op   = alu_op_decode(funct3, if_id_instr[30], 1'b0);
        imm           = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
        uses_rs1      = 1'b1;
        writes_rd     = 1'b1;
      end
      OP_LOAD: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        imm           = imm_i;
        uses_rs1      = 1'b1;
        writes_rd     = 1'b1;
      end
      OP_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        imm           = imm_s;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        imm       = imm_b;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        is_branch = 1'b1;
      end
      default: ;
    endcase
  end

  logic rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit, hazard;

  assign rs1_ex_hit  = uses_rs1 && (rs1_f != '0) && (rs1_f == ex_rd);
  assign rs2_ex_hit  = uses_rs2 && (rs2_f != '0) && (rs2_f == ex_rd);
  assign rs1_mem_hit = (rs1_f != '0) && (rs1_f == ex_mem_rd);
  assign rs2_mem_hit = (rs2_f != '0) && (rs2_f == ex_mem_rd);

  // A branch on a load result waits out both the EX and the MEM stage of that load.
  assign hazard = if_id_valid &&
                  ((ex_memread && (rs1_ex_hit || rs2_ex_hit)) ||
                   (is_branch && ex_regwrite && (rs1_ex_hit || rs2_ex_hit)) ||
                   (is_branch && ex_mem_memread && (rs1_mem_hit || rs2_mem_hit)));

  logic [XLEN-1:0] cmp_a, cmp_b;
  logic            taken;

  always_comb begin
    cmp_a = rf_rs1_val;
    cmp_b = rf_rs2_val;
    if (ex_mem_regwrite && !ex_mem_memread && rs1_mem_hit)
      cmp_a = ex_mem_result;
    else if (mem_wb_regwrite && (rs1_f != '0) && (rs1_f == mem_wb_rd))
      cmp_a = mem_wb_data;
    if (ex_mem_regwrite && !ex_mem_memread && rs2_mem_hit)
      cmp_b = ex_mem_result;
    else if (mem_wb_regwrite && (rs2_f != '0) && (rs2_f == mem_wb_rd))
      cmp_b = mem_wb_data;
  end

  branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
    .a      (cmp_a),
    .b      (cmp_b),
    .funct3 (funct3),
    .taken  (taken)
  );

  assign stall         = if_id_valid && (ex_hold || hazard);
  assign flush_if      = if_id_valid && is_branch && taken && !ex_hold && !hazard;
  assign branch_target = if_id_pc + imm_b;

  idex_t idex_q, idex_d;

  always_comb begin
    idex_d         = '0;
    idex_d.valid   = if_id_valid;
    idex_d.ctrl    = ctrl;
    idex_d.rs1     = uses_rs1 ? rs1_f : '0;
    idex_d.rs2     = uses_rs2 ? rs2_f : '0;
    idex_d.rd      = writes_rd ? rd_f : '0;
    idex_d.imm     = imm;
    idex_d.rs1_val = rf_rs1_val;
    idex_d.rs2_val = rf_rs2_val;
    idex_d.pc      = if_id_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      idex_q <= '0;
    else if (ex_hold)
      idex_q <= idex_q;
    else if (hazard)
      idex_q <= '0;
    else
      idex_q <= idex_d;
  end

  assign ex_valid    = idex_q.valid;
  assign ex_regwrite = idex_q.ctrl.regwrite;
  assign ex_memread  = idex_q.ctrl.memread;
  assign ex_memwrite = idex_q.ctrl.memwrite;
  assign ex_memtoreg = idex_q.ctrl.memtoreg;
  assign ex_alu_src  = idex_q.ctrl.alu_src;
  assign ex_alu_op   = idex_q.ctrl.alu_op;
  assign ex_rs1      = idex_q.rs1;
  assign ex_rs2      = idex_q.rs2;
  assign ex_rd       = idex_q.rd;
  assign ex_imm      = idex_q.imm;
  assign ex_rs1_val  = idex_q.rs1_val;
  assign ex_rs2_val  = idex_q.rs2_val;
  assign ex_pc       = idex_q.pc;

`ifdef ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Only hazard stalls count; back-pressure stalls belong to the downstream stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard && !ex_hold)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_if)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed self-checking bench for id_stage_pipe (XLEN=64).
`default_nettype none

module tb_id_stage_pipe;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;
`ifdef ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_id_valid;
  logic [31:0]       if_id_instr;
  logic [XLEN-1:0]   if_id_pc, rf_rs1_val, rf_rs2_val;
  logic [REG_AW-1:0] ex_mem_rd, mem_wb_rd;
  logic              ex_mem_regwrite, ex_mem_memread, mem_wb_regwrite, ex_hold;
  logic [XLEN-1:0]   ex_mem_result, mem_wb_data;
  logic              stall, flush_if;
  logic [XLEN-1:0]   branch_target;
  logic              ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alu_src;
  logic [3:0]        ex_alu_op;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0]   ex_imm, ex_rs1_val, ex_rs2_val, ex_pc;
  logic [CNT_W-1:0]  stall_cycles, flush_count;

  id_stage_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
    .ex_mem_result(ex_mem_result), .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_data(mem_wb_data), .ex_hold(ex_hold), .stall(stall), .flush_if(flush_if),
    .branch_target(branch_target), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_pc(ex_pc), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [6:0] op, input logic [11:0] imm,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_ins(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_ins(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic clear_fwd();
    ex_mem_rd = '0; ex_mem_regwrite = 1'b0; ex_mem_memread = 1'b0; ex_mem_result = '0;
    mem_wb_rd = '0; mem_wb_regwrite = 1'b0; mem_wb_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; if_id_valid = 1'b1; ex_hold = 1'b0;
    if_id_instr = r_ins(7'd0, 5'd2, 5'd5, 3'b000, 5'd6);
    if_id_pc = 64'h8; rf_rs1_val = 64'h5; rf_rs2_val = 64'h6;
    clear_fwd();
    step(); step();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_rd", ex_rd, 0);
    check("rst_ex_pc", ex_pc, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_flush_count", flush_count, 0);

    // Load-use: ld x5,0(x1) ; add x6,x5,x2
    rst_n = 1'b1;
    if_id_instr = i_ins(7'b0000011, 12'd0, 5'd1, 3'b011, 5'd5);
    if_id_pc = 64'h40; rf_rs1_val = 64'h1000; rf_rs2_val = 64'h2000;
    #1 check("t1_ld_stall", stall, 0);
    step();
    check("t1_ld_valid", ex_valid, 1);
    check("t1_ld_memread", ex_memread, 1);
    check("t1_ld_memtoreg", ex_memtoreg, 1);
    check("t1_ld_alu_src", ex_alu_src, 1);
    check("t1_ld_alu_op", ex_alu_op, 4'b0010);
    check("t1_ld_rd", ex_rd, 5);
    check("t1_ld_rs2", ex_rs2, 0);
    check("t1_ld_rs1_val", ex_rs1_val, 64'h1000);
    check("t1_ld_pc", ex_pc, 64'h40);
    if_id_instr = r_ins(7'd0, 5'd2, 5'd5, 3'b000, 5'd6);
    if_id_pc = 64'h44;
    #1 check("t1_lu_stall", stall, 1);
    check("t1_lu_flush", flush_if, 0);
    step();
    check("t1_bubble_valid", ex_valid, 0);
    check("t1_bubble_memread", ex_memread, 0);
    check("t1_bubble_rd", ex_rd, 0);
    check("t1_after_stall", stall, 0);
    step();
    check("t1_add_valid", ex_valid, 1);
    check("t1_add_rd", ex_rd, 6);
    check("t1_add_rs1", ex_rs1, 5);
    check("t1_add_rs2", ex_rs2, 2);
    check("t1_add_regwrite", ex_regwrite, 1);
    check("t1_add_alu_src", ex_alu_src, 0);
    check("t1_add_alu_op", ex_alu_op, 4'b0010);
    check("t1_stall_cycles", stall_cycles, PERF ? 64'd1 : 64'd0);

    // Extra decode patterns: sub, srai with 6-bit shamt, sd, unknown opcode
    if_id_instr = r_ins(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd7);
    step();
    check("dec_sub_op", ex_alu_op, 4'b0110);
    if_id_instr = i_ins(7'b0010011, 12'h421, 5'd1, 3'b101, 5'd8);
    step();
    check("dec_srai_op", ex_alu_op, 4'b0101);
    check("dec_srai_imm", ex_imm, 64'd33);
    check("dec_srai_alu_src", ex_alu_src, 1);
    if_id_instr = s_ins(12'hFF8, 5'd2, 5'd1, 3'b011);
    step();
    check("dec_sd_memwrite", ex_memwrite, 1);
    check("dec_sd_regwrite", ex_regwrite, 0);
    check("dec_sd_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check("dec_sd_rd", ex_rd, 0);
    check("dec_sd_rs2", ex_rs2, 2);
    if_id_instr = 32'h0000_007F;
    step();
    check("dec_unk_valid", ex_valid, 1);
    check("dec_unk_regwrite", ex_regwrite, 0);
    check("dec_unk_alu_op", ex_alu_op, 4'b0000);

    // Taken BEQ with register-file operands
    if_id_instr = b_ins(13'd16, 5'd2, 5'd1, 3'b000);
    if_id_pc = 64'h100; rf_rs1_val = 64'd7; rf_rs2_val = 64'd7;
    #1 check("t2_beq_flush", flush_if, 1);
    check("t2_beq_target", branch_target, 64'h110);
    check("t2_beq_stall", stall, 0);
    if_id_instr = b_ins(13'd16, 5'd2, 5'd1, 3'b001);
    #1 check("t2_bne_flush", flush_if, 0);
    if_id_instr = b_ins(13'd16, 5'd2, 5'd1, 3'b010);
    #1 check("t2_f3_010_flush", flush_if, 0);
    if_id_instr = b_ins(13'd16, 5'd2, 5'd1, 3'b000);
    step();
    check("t2_flush_count", flush_count, PERF ? 64'd1 : 64'd0);
    check("t2_br_regwrite", ex_regwrite, 0);
    check("t2_br_imm", ex_imm, 64'd16);

    // EX/MEM forwarding of -1 into unsigned / signed compares, EX/MEM beats MEM/WB
    rf_rs1_val = 64'd0; rf_rs2_val = 64'd0; if_id_pc = 64'h180;
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1; ex_mem_result = '1;
    mem_wb_rd = 5'd3; mem_wb_regwrite = 1'b1; mem_wb_data = 64'd5;
    if_id_instr = b_ins(13'd8, 5'd3, 5'd0, 3'b110);
    #1 check("t3_bltu_flush", flush_if, 1);
    check("t3_bltu_target", branch_target, 64'h188);
    if_id_instr = b_ins(13'd8, 5'd3, 5'd0, 3'b100);
    #1 check("t3_blt_flush", flush_if, 0);
    ex_mem_memread = 1'b1;
    #1 check("t3_memread_stall", stall, 1);
    check("t3_memread_flush", flush_if, 0);
    clear_fwd();
    if_id_valid = 1'b0;
    step();
    check("t3_idle_valid", ex_valid, 0);
    check("t3_flush_count", flush_count, PERF ? 64'd1 : 64'd0);

    // Branch on a load result: two stall cycles, then MEM/WB forwarding
    if_id_valid = 1'b1;
    if_id_instr = i_ins(7'b0000011, 12'd0, 5'd1, 3'b011, 5'd4);
    if_id_pc = 64'h1FC;
    step();
    if_id_instr = b_ins(13'd12, 5'd0, 5'd4, 3'b000);
    if_id_pc = 64'h200; rf_rs1_val = 64'h99; rf_rs2_val = 64'd0;
    if_id_valid = 1'b0;
    #1 check("t4_invalid_stall", stall, 0);
    if_id_valid = 1'b1;
    #1 check("t4_stall1", stall, 1);
    check("t4_flush1", flush_if, 0);
    step();
    check("t4_bubble1", ex_valid, 0);
    ex_mem_rd = 5'd4; ex_mem_regwrite = 1'b1; ex_mem_memread = 1'b1; ex_mem_result = 64'h1234;
    #1 check("t4_stall2", stall, 1);
    step();
    check("t4_bubble2", ex_valid, 0);
    clear_fwd();
    mem_wb_rd = 5'd4; mem_wb_regwrite = 1'b1; mem_wb_data = 64'd0;
    #1 check("t4_resolved_stall", stall, 0);
    check("t4_resolved_flush", flush_if, 1);
    check("t4_target", branch_target, 64'h20C);
    step();
    check("t4_br_valid", ex_valid, 1);
    check("t4_br_pc", ex_pc, 64'h200);
    check("t4_stall_cycles", stall_cycles, PERF ? 64'd3 : 64'd0);
    check("t4_flush_count", flush_count, PERF ? 64'd2 : 64'd0);

    // ex_hold for three cycles freezes ID/EX
    clear_fwd();
    if_id_instr = r_ins(7'd0, 5'd2, 5'd1, 3'b000, 5'd9);
    if_id_pc = 64'h300; rf_rs1_val = 64'h11; rf_rs2_val = 64'h22;
    step();
    check("t5_add_rd", ex_rd, 9);
    if_id_instr = r_ins(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd10);
    if_id_pc = 64'h304; rf_rs1_val = 64'h33;
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("t5_hold_stall", stall, 1);
      check("t5_hold_flush", flush_if, 0);
      step();
      check("t5_hold_rd", ex_rd, 9);
      check("t5_hold_op", ex_alu_op, 4'b0010);
      check("t5_hold_rs1_val", ex_rs1_val, 64'h11);
      check("t5_hold_pc", ex_pc, 64'h300);
    end
    check("t5_stall_cycles", stall_cycles, PERF ? 64'd3 : 64'd0);
    ex_hold = 1'b0;
    step();
    check("t5_release_rd", ex_rd, 10);
    check("t5_release_op", ex_alu_op, 4'b0110);

    // Reset in the middle of a load-branch stall
    if_id_instr = i_ins(7'b0000011, 12'd0, 5'd1, 3'b011, 5'd4);
    if_id_pc = 64'h400;
    step();
    if_id_instr = b_ins(13'd12, 5'd0, 5'd4, 3'b000);
    if_id_pc = 64'h404; rf_rs1_val = 64'h99; rf_rs2_val = 64'd0;
    #1 check("t6_pre_stall", stall, 1);
    rst_n = 1'b0;
    step();
    check("t6_ex_valid", ex_valid, 0);
    check("t6_ex_memread", ex_memread, 0);
    check("t6_ex_rd", ex_rd, 0);
    check("t6_ex_pc", ex_pc, 0);
    check("t6_stall_cycles", stall_cycles, 0);
    check("t6_flush_count", flush_count, 0);
    rst_n = 1'b1;
    #1 check("t6_restart_stall", stall, 0);
    step();
    check("t6_restart_valid", ex_valid, 1);
    check("t6_restart_pc", ex_pc, 64'h404);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
